// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial WIDTH-bit adder.
// A single full-adder cell (two half-adder stages plus an OR on the carries)
// and a carry flop process one bit per clock, LSB first. {cout,sum} is
// a + b + cin, and a one-cycle done pulse marks each completed result.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // RUN leaves at count WIDTH-1, so this counter can never wrap.
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cout_q, cout_d;

  logic             ha0_s, ha0_c;
  logic             s_bit, c_next;
  logic [WIDTH-1:0] res_shift;

  // Full-adder cell on the current LSBs, and the result register shifted
  // right with the new sum bit entering at the MSB.
  always_comb begin
    ha0_s     = a_q[0] ^ b_q[0];
    ha0_c     = a_q[0] & b_q[0];
    s_bit     = ha0_s ^ carry_q;
    c_next    = ha0_c | (ha0_s & carry_q);
    res_shift = res_q >> 1;
    // Writing only the top bit keeps this legal when WIDTH is 1.
    res_shift[WIDTH-1] = s_bit;
  end

  // Next-state logic for the IDLE/RUN controller and the datapath.
  always_comb begin
    // NOTE: every signal assigned here first takes its hold value. That way no
    // branch can leave a signal unassigned, and no latch is inferred.
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sum_d   = sum_q;
    cout_d  = cout_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        res_d   = res_shift;
        carry_d = c_next;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          // The last bit goes straight to the result. Sum and cout change only here.
          sum_d   = res_shift;
          cout_d  = c_next;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset. Reset also drops any partial result.
  always_ff @(posedge clk) begin
    // NOTE: use non-blocking assignments for all state here. Every flop then
    // samples values from before the edge, whatever order they are written in.
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule
